dtw_sched_dispatch: RTL and testbench
=====================================

// Module: dtw_sched_dispatch
// PURPOSE
//  Sits between the host stream FIFOs and NUM_CORES dtw_core instances. Broadcasts the reference once,
//  then deals each query frame (1 ID word + SQG_SIZE samples) to a free core, round-robin.
//  A concurrent collector merges the 3-word result records (qid, position, minval) into one output stream.
// PARAMETERS
//  NUM_CORES   4    number of dtw_core instances served (1..16)
//  SQG_SIZE    250  samples per query frame, excluding the ID word
//  AXIS_WIDTH  32   stream word width
// PORTS
//  clk             in   1          single clock
//  rst             in   1          asynchronous, active-high reset
//  ref_len         in   32         reference length in words; held stable while loading
//  ref_load_start  in   1          one-cycle pulse; starts the reference broadcast
//  ref_loaded      out  1          high once every core reports load_done
//  in_empty        in   1          upstream FWFT FIFO empty
//  in_data         in   32         upstream head word; valid while !in_empty
//  in_rden         out  1          pops the upstream FIFO
//  core_rs         out  N          per-core run-start pulse
//  core_op_mode    out  1          mode for all cores: 1 = load reference, 0 = query
//  core_busy       in   N          per-core busy
//  core_load_done  in   N          per-core reference-loaded flag
//  core_fifo_wren  out  N          per-core source FIFO write enable
//  core_fifo_full  in   N          per-core source FIFO full
//  core_fifo_data  out  32         shared source FIFO write data
//  res_empty       in   N          per-core result FWFT FIFO empty
//  res_data        in   N*32       per-core result head words; core i on [32i+31:32i]
//  res_rden        out  N          per-core result FIFO pop
//  out_wren        out  1          output FIFO write
//  out_full        in   1          output FIFO full
//  out_data        out  32         output word
//  n_dispatched    out  32         count of query frames fully streamed
//  n_collected     out  32         count of complete result records forwarded
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs return to IDLE; ref_loaded=0; counters=0; RR pointers=0.
//   A frame in flight at reset is abandoned; cores must be reset at the same time.
//  Word transfer (combinational): xfer = active && !in_empty && !dest_full.
//   When xfer: in_rden=1, the selected wren=1, core_fifo_data=in_data. No registered slop.
//  Dispatcher FSM:
//   IDLE
//    ref_load_start && !ref_loaded && ref_len!=0 -> REF_START
//    Otherwise ignored (ref_len=0 would hang the cores).
//    With ref_loaded and some core free -> Q_SELECT.
//   REF_START (1 cycle): core_rs=all 1s, core_op_mode=1, word count=0 -> REF_BCAST.
//   REF_BCAST: writes go to all cores at once.
//    dest_full = |core_fifo_full; the count increments on each xfer.
//    count==ref_len -> REF_WAIT.
//   REF_WAIT: &core_load_done -> ref_loaded=1, IDLE. ref_loaded holds until rst.
//   Free core: load_done && !busy && !pending.
//    pending[i] is set on core_rs[i]; it clears on the first cycle core_busy[i]=1.
//   Q_SELECT (1 cycle): RR pick starts at last_core+1; latch sel -> Q_START.
//   Q_START (1 cycle): core_rs[sel]=1, core_op_mode=0, count=0 -> Q_STREAM.
//   Q_STREAM: dest_full = core_fifo_full[sel].
//    count reaches SQG_SIZE+1 -> n_dispatched++, last_core=sel, IDLE.
//   Minimum gap between frames is 3 cycles (IDLE, Q_SELECT, Q_START).
//   Upstream empty stalls the transfer indefinitely; there is no timeout.
//  Collector FSM (independent, concurrent with the dispatcher):
//   C_IDLE: RR pick among !res_empty -> C_MOVE with csel latched, wcnt=0.
//   C_MOVE: fire = !res_empty[csel] && !out_full.
//    When fire: res_rden[csel]=1, out_wren=1, out_data=res_data[csel], wcnt++.
//    A record is 3 words and is never split; csel holds until wcnt==3.
//    Then n_collected++, C_IDLE. The pointer advances past csel.
//  Counters wrap at 2^32. Same-cycle rs and busy-rise on one core: pending clears next cycle.
// STRUCTURE
//  Shared package dtw_sched_pkg holds:
//   - dispatcher and collector state encodings
//   - MODE_QUERY=0 and MODE_LOAD_REF=1
//   - RECORD_WORDS=3
//  Sub-module dtw_rr_picker #(N): inputs req[N] and base ptr; outputs one-hot grant and index.
//   Purely combinational; instantiated twice, once per FSM.
// TESTING
//  1. Reference load, ref_len=1000, N=4, all FIFOs non-full:
//     -> one 4-bit rs pulse with op_mode=1; exactly 1000 broadcast writes; ref_loaded rises after all 4 load_done.
//  2. Eight back-to-back frames, cores idle:
//     -> frames go to cores 0,1,2,3,0,1,2,3; each gets 251 writes; n_dispatched=8.
//  3. Core 1 busy, cores 0,2,3 free, last_core=0:
//     -> the next frame goes to core 2; core 1 is never written.
//  4. core_fifo_full[sel] toggles every 3rd cycle and in_empty randomly:
//     -> zero writes while full; the sequence arrives intact and in order.
//  5. Cores 0 and 2 each hold one record, out_full for 5 cycles mid-record:
//     -> out stream is core 0's 3 words, then core 2's 3 words, never interleaved; n_collected=2.
//  6. rst asserted mid Q_STREAM at word 100:
//     -> outputs go to 0 immediately; counters=0; ref_loaded=0.
//  7. ref_load_start with ref_len=0, or while ref_loaded=1:
//     -> no rs, no writes; FSM stays in IDLE.

Source files
------------

// File: rtl/dtw_sched_pkg.sv
// Shared encodings and constants for the DTW query scheduler/dispatcher.
package dtw_sched_pkg;

  typedef enum logic [2:0] {
    D_IDLE,
    D_REF_START,
    D_REF_BCAST,
    D_REF_WAIT,
    D_Q_SELECT,
    D_Q_START,
    D_Q_STREAM
  } disp_state_t;

  typedef enum logic {
    C_IDLE,
    C_MOVE
  } coll_state_t;

  localparam logic MODE_QUERY    = 1'b0;
  localparam logic MODE_LOAD_REF = 1'b1;

  localparam int RECORD_WORDS = 3;

endpackage

// File: rtl/dtw_rr_picker.sv
// Combinational round-robin picker: first requester at or after base, wrapping.
module dtw_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  // Scan the requesters cyclically from base; the first hit wins.
  always_comb begin
    int c;
    grant = '0;
    index = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(base) + k) % N;
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        index    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/dtw_sched_dispatch.sv
// Reference broadcaster, round-robin query dealer and result collector for a DTW core array.
module dtw_sched_dispatch
  import dtw_sched_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int SQG_SIZE   = 250,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     ref_len,
  input  logic                            ref_load_start,
  output logic                            ref_loaded,
  input  logic                            in_empty,
  input  logic [AXIS_WIDTH-1:0]           in_data,
  output logic                            in_rden,
  output logic [NUM_CORES-1:0]            core_rs,
  output logic                            core_op_mode,
  input  logic [NUM_CORES-1:0]            core_busy,
  input  logic [NUM_CORES-1:0]            core_load_done,
  output logic [NUM_CORES-1:0]            core_fifo_wren,
  input  logic [NUM_CORES-1:0]            core_fifo_full,
  output logic [AXIS_WIDTH-1:0]           core_fifo_data,
  input  logic [NUM_CORES-1:0]            res_empty,
  input  logic [NUM_CORES*AXIS_WIDTH-1:0] res_data,
  output logic [NUM_CORES-1:0]            res_rden,
  output logic                            out_wren,
  input  logic                            out_full,
  output logic [AXIS_WIDTH-1:0]           out_data,
  output logic [31:0]                     n_dispatched,
  output logic [31:0]                     n_collected
);

  localparam int          IW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0] FRAME_WORDS = 32'(SQG_SIZE + 1);

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    if (int'(p) == NUM_CORES - 1) return '0;
    return p + IW'(1);
  endfunction

  disp_state_t            d_state, d_next;
  logic [31:0]            cnt;
  logic [IW-1:0]          sel, d_ptr, d_idx;
  logic [NUM_CORES-1:0]   sel_oh, d_grant, pending, core_free;
  logic                   d_valid, xfer;

  coll_state_t            c_state, c_next;
  logic [IW-1:0]          csel, c_ptr, c_idx;
  logic [NUM_CORES-1:0]   csel_oh, c_grant, res_avail;
  logic                   c_valid, fire;
  logic [1:0]             wcnt;

  // A core may take a frame only once loaded, idle, and not still owed a busy rise.
  assign core_free = core_load_done & ~core_busy & ~pending;
  assign res_avail = ~res_empty;

  dtw_rr_picker #(.N(NUM_CORES), .IW(IW)) u_disp_pick (
    .req  (core_free),
    .base (d_ptr),
    .grant(d_grant),
    .index(d_idx),
    .valid(d_valid)
  );

  dtw_rr_picker #(.N(NUM_CORES), .IW(IW)) u_coll_pick (
    .req  (res_avail),
    .base (c_ptr),
    .grant(c_grant),
    .index(c_idx),
    .valid(c_valid)
  );

  // Dispatcher next state and the combinational upstream-to-core word path.
  always_comb begin
    d_next         = d_state;
    core_rs        = '0;
    core_op_mode   = MODE_QUERY;
    core_fifo_wren = '0;
    core_fifo_data = '0;
    in_rden        = 1'b0;
    xfer           = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (ref_load_start && !ref_loaded && ref_len != 32'd0) d_next = D_REF_START;
        else if (ref_loaded && |core_free)                     d_next = D_Q_SELECT;
      end
      D_REF_START: begin
        core_rs      = '1;
        core_op_mode = MODE_LOAD_REF;
        d_next       = D_REF_BCAST;
      end
      D_REF_BCAST: begin
        core_op_mode = MODE_LOAD_REF;
        xfer         = !in_empty && !(|core_fifo_full);
        if (xfer) begin
          in_rden        = 1'b1;
          core_fifo_wren = '1;
          core_fifo_data = in_data;
          if (cnt + 32'd1 == ref_len) d_next = D_REF_WAIT;
        end
      end
      D_REF_WAIT: begin
        core_op_mode = MODE_LOAD_REF;
        if (&core_load_done) d_next = D_IDLE;
      end
      D_Q_SELECT: begin
        d_next = d_valid ? D_Q_START : D_IDLE;
      end
      D_Q_START: begin
        core_rs = sel_oh;
        d_next  = D_Q_STREAM;
      end
      D_Q_STREAM: begin
        xfer = !in_empty && !(|(core_fifo_full & sel_oh));
        if (xfer) begin
          in_rden        = 1'b1;
          core_fifo_wren = sel_oh;
          core_fifo_data = in_data;
          if (cnt + 32'd1 == FRAME_WORDS) d_next = D_IDLE;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  // Dispatcher state, word count, selected core, RR pointer and load flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state      <= D_IDLE;
      cnt          <= '0;
      sel          <= '0;
      sel_oh       <= '0;
      d_ptr        <= '0;
      ref_loaded   <= 1'b0;
      n_dispatched <= '0;
    end else begin
      d_state <= d_next;
      if (d_state == D_REF_START || d_state == D_Q_START) cnt <= '0;
      else if (xfer)                                       cnt <= cnt + 32'd1;
      if (d_state == D_REF_WAIT && &core_load_done) ref_loaded <= 1'b1;
      if (d_state == D_Q_SELECT && d_valid) begin
        sel    <= d_idx;
        sel_oh <= d_grant;
      end
      if (d_state == D_Q_STREAM && d_next == D_IDLE) begin
        n_dispatched <= n_dispatched + 32'd1;
        d_ptr        <= next_ptr(sel);
      end
    end
  end

  // A started core stays reserved until it reports busy at least once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= core_rs | (pending & ~core_busy);
  end

  // Collector next state and the result-to-output word path; records are never split.
  always_comb begin
    c_next   = c_state;
    res_rden = '0;
    out_wren = 1'b0;
    out_data = '0;
    fire     = 1'b0;
    case (c_state)
      C_IDLE: begin
        if (c_valid) c_next = C_MOVE;
      end
      C_MOVE: begin
        fire = !(|(res_empty & csel_oh)) && !out_full;
        if (fire) begin
          res_rden = csel_oh;
          out_wren = 1'b1;
          out_data = res_data[int'(csel)*AXIS_WIDTH +: AXIS_WIDTH];
          if (wcnt == 2'(RECORD_WORDS - 1)) c_next = C_IDLE;
        end
      end
      default: c_next = C_IDLE;
    endcase
  end

  // Collector state, latched source, word count and RR pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state     <= C_IDLE;
      csel        <= '0;
      csel_oh     <= '0;
      c_ptr       <= '0;
      wcnt        <= '0;
      n_collected <= '0;
    end else begin
      c_state <= c_next;
      if (c_state == C_IDLE && c_valid) begin
        csel    <= c_idx;
        csel_oh <= c_grant;
        wcnt    <= '0;
      end else if (fire) begin
        wcnt <= wcnt + 2'd1;
        if (c_next == C_IDLE) begin
          n_collected <= n_collected + 32'd1;
          c_ptr       <= next_ptr(csel);
        end
      end
    end
  end

endmodule

// File: tb/tb_dtw_sched_dispatch.sv
// Randomized self-checking bench for dtw_sched_dispatch with a queue-based reference model.
module tb_dtw_sched_dispatch;

  localparam int N  = 4;
  localparam int SQ = 250;
  localparam int W  = 32;
  localparam int FW = SQ + 1;

  logic             clk, rst;
  logic [31:0]      ref_len;
  logic             ref_load_start, ref_loaded;
  logic             in_empty, in_rden;
  logic [W-1:0]     in_data;
  logic [N-1:0]     core_rs, core_busy, core_load_done, core_fifo_wren, core_fifo_full;
  logic             core_op_mode;
  logic [W-1:0]     core_fifo_data;
  logic [N-1:0]     res_empty, res_rden;
  logic [N*W-1:0]   res_data;
  logic             out_wren, out_full;
  logic [W-1:0]     out_data;
  logic [31:0]      n_dispatched, n_collected;

  dtw_sched_dispatch #(.NUM_CORES(N), .SQG_SIZE(SQ), .AXIS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ref_len(ref_len), .ref_load_start(ref_load_start),
    .ref_loaded(ref_loaded), .in_empty(in_empty), .in_data(in_data), .in_rden(in_rden),
    .core_rs(core_rs), .core_op_mode(core_op_mode), .core_busy(core_busy),
    .core_load_done(core_load_done), .core_fifo_wren(core_fifo_wren),
    .core_fifo_full(core_fifo_full), .core_fifo_data(core_fifo_data),
    .res_empty(res_empty), .res_data(res_data), .res_rden(res_rden),
    .out_wren(out_wren), .out_full(out_full), .out_data(out_data),
    .n_dispatched(n_dispatched), .n_collected(n_collected)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [N-1:0] mask; logic [31:0] data; } wr_t;
  typedef struct packed { logic [N-1:0] mask; logic mode; } rs_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] up_q[$];
  logic [31:0] res_q[N][$];
  wr_t         wr_log[$];
  rs_t         rs_log[$];
  logic [31:0] out_log[$];
  logic [31:0] exp_words[$];
  int          exp_cores[$];
  int          btimer[N];
  logic [N-1:0] force_busy = '0;
  logic [N-1:0] load_done_k = '0;
  int          stall_pct = 0;
  bit          full_mode = 1'b0;
  int          ofull_cnt = 0;
  int          wr_full_viol = 0, rden_bad = 0, out_full_viol = 0, res_pop_bad = 0;
  int          exp_dptr = 0;

  // Round-robin rule from the design description: first available index at or after ptr.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] avail);
    for (int k = 0; k < N; k++) if (avail[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Present the environment models on the DUT inputs.
  task automatic drive();
    in_empty = (up_q.size() == 0) || (int'($urandom_range(99)) < stall_pct);
    in_data  = (up_q.size() != 0) ? up_q[0] : '0;
    for (int i = 0; i < N; i++) begin
      core_busy[i] = force_busy[i] || (btimer[i] > 0);
      res_empty[i] = (res_q[i].size() == 0);
      res_data[i*W +: W] = (res_q[i].size() != 0) ? res_q[i][0] : '0;
    end
    core_load_done = load_done_k;
    core_fifo_full = (full_mode && (cyc % 3 == 0)) ? '1 : '0;
    out_full       = (ofull_cnt > 0);
  endtask

  // One clock: log DUT activity at the negedge, update the models just after the posedge.
  task automatic step();
    logic         pop_up;
    logic [N-1:0] rs_seen, res_pop;
    @(negedge clk);
    if (core_rs != '0) rs_log.push_back('{core_rs, core_op_mode});
    if (core_fifo_wren != '0) begin
      wr_log.push_back('{core_fifo_wren, core_fifo_data});
      if ((core_fifo_wren & core_fifo_full) != '0) wr_full_viol++;
    end
    if ((in_rden !== (|core_fifo_wren)) || (in_rden && in_empty) ||
        (in_rden && core_fifo_data !== in_data)) rden_bad++;
    if (out_wren) begin
      out_log.push_back(out_data);
      if (out_full) out_full_viol++;
    end
    if ((res_rden & res_empty) != '0) res_pop_bad++;
    pop_up  = in_rden && !in_empty;
    rs_seen = core_rs;
    res_pop = res_rden & ~res_empty;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_up) void'(up_q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (res_pop[i]) void'(res_q[i].pop_front());
      if (rs_seen[i]) btimer[i] = 2;
      else if (btimer[i] > 0) btimer[i]--;
    end
    if (ofull_cnt > 0) ofull_cnt--;
    drive();
  endtask

  task automatic push_frame(input int core);
    logic [31:0] w;
    for (int j = 0; j < FW; j++) begin
      w = $urandom();
      up_q.push_back(w);
      exp_words.push_back(w);
    end
    exp_cores.push_back(core);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int t;
    t = 0;
    while (wr_log.size() < target && t < budget) begin
      step();
      t++;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rs_log.delete();
    out_log.delete();
    exp_words.delete();
    exp_cores.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ref_len = '0;
    ref_load_start = 1'b0;
    for (int i = 0; i < N; i++) btimer[i] = 0;
    drive();
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (in_rden !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_rden: got %b expected 0", in_rden); end
    checks++; if (core_rs !== '0) begin errors++; $display("[TB] FAIL reset_core_rs: got %b expected 0", core_rs); end
    checks++; if (core_fifo_wren !== '0) begin errors++; $display("[TB] FAIL reset_wren: got %b expected 0", core_fifo_wren); end
    checks++; if (core_op_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_op_mode: got %b expected 0", core_op_mode); end
    checks++; if (out_wren !== 1'b0 || res_rden !== '0) begin errors++; $display("[TB] FAIL reset_collector: out_wren %b res_rden %b expected 0", out_wren, res_rden); end
    checks++; if (ref_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_ref_loaded: got %b expected 0", ref_loaded); end
    checks++; if (n_dispatched !== 32'd0 || n_collected !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", n_dispatched, n_collected); end
  endtask

  task automatic test_ref_len_zero();
    clear_logs();
    ref_len = 32'd0;
    ref_load_start = 1'b1;
    step();
    ref_load_start = 1'b0;
    repeat (20) step();
    checks++; if (rs_log.size() != 0) begin errors++; $display("[TB] FAIL zero_len_rs: got %0d pulses expected 0", rs_log.size()); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("[TB] FAIL zero_len_writes: got %0d expected 0", wr_log.size()); end
  endtask

  task automatic test_ref_load();
    int bad;
    clear_logs();
    ref_len = 32'd1000;
    for (int j = 0; j < 1000; j++) begin
      exp_words.push_back($urandom());
      up_q.push_back(exp_words[j]);
    end
    drive();
    ref_load_start = 1'b1;
    step();
    ref_load_start = 1'b0;
    wait_writes(1000, 1500);
    repeat (5) step();
    checks++; if (rs_log.size() != 1) begin errors++; $display("[TB] FAIL ref_rs_count: got %0d expected 1", rs_log.size()); end
    else begin
      checks++; if (rs_log[0].mask !== 4'hF || rs_log[0].mode !== 1'b1) begin errors++; $display("[TB] FAIL ref_rs_pulse: got mask %h mode %b expected f/1", rs_log[0].mask, rs_log[0].mode); end
    end
    checks++; if (wr_log.size() != 1000) begin errors++; $display("[TB] FAIL ref_write_count: got %0d expected 1000", wr_log.size()); end
    else begin
      bad = 0;
      for (int j = 0; j < 1000; j++) if (wr_log[j].mask !== 4'hF || wr_log[j].data !== exp_words[j]) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ref_broadcast_data: %0d bad words expected 0", bad); end
    end
    for (int i = 0; i < N - 1; i++) begin
      load_done_k[i] = 1'b1;
      drive();
      repeat (3) step();
      checks++; if (ref_loaded !== 1'b0) begin errors++; $display("[TB] FAIL ref_loaded_early: got %b expected 0 with load_done %b", ref_loaded, load_done_k); end
    end
    load_done_k = '1;
    drive();
    repeat (3) step();
    checks++; if (ref_loaded !== 1'b1) begin errors++; $display("[TB] FAIL ref_loaded_final: got %b expected 1", ref_loaded); end
  endtask

  task automatic test_reload_ignored();
    int mode1;
    clear_logs();
    ref_len = 32'd1000;
    ref_load_start = 1'b1;
    step();
    ref_load_start = 1'b0;
    repeat (20) step();
    mode1 = 0;
    foreach (rs_log[k]) if (rs_log[k].mode == 1'b1) mode1++;
    checks++; if (mode1 != 0) begin errors++; $display("[TB] FAIL reload_rs: got %0d load pulses expected 0", mode1); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("[TB] FAIL reload_writes: got %0d expected 0", wr_log.size()); end
  endtask

  // Checks every logged frame against the model's expected core and contents.
  task automatic check_frames(input int nf, input int base_disp);
    logic [N-1:0] oh;
    int bm, bd;
    checks++; if (wr_log.size() != nf * FW) begin errors++; $display("[TB] FAIL frame_writes: got %0d expected %0d", wr_log.size(), nf * FW); end
    else begin
      for (int f = 0; f < nf; f++) begin
        oh = '0;
        oh[exp_cores[f]] = 1'b1;
        bm = 0;
        bd = 0;
        for (int j = 0; j < FW; j++) begin
          if (wr_log[f*FW+j].mask !== oh) bm++;
          if (wr_log[f*FW+j].data !== exp_words[f*FW+j]) bd++;
        end
        checks++; if (bm != 0) begin errors++; $display("[TB] FAIL frame%0d_core: %0d words off core %0d (first mask %b)", f, bm, exp_cores[f], wr_log[f*FW].mask); end
        checks++; if (bd != 0) begin errors++; $display("[TB] FAIL frame%0d_data: %0d bad words expected 0", f, bd); end
      end
    end
    checks++; if (n_dispatched !== 32'(base_disp + nf)) begin errors++; $display("[TB] FAIL n_dispatched: got %0d expected %0d", n_dispatched, base_disp + nf); end
  endtask

  task automatic test_back_to_back();
    int c;
    clear_logs();
    for (int f = 0; f < 8; f++) begin
      c = rr_pick(exp_dptr, ~force_busy);
      exp_dptr = (c + 1) % N;
      push_frame(c);
    end
    drive();
    wait_writes(8 * FW, 8 * FW + 200);
    step();
    check_frames(8, 0);
  endtask

  task automatic test_busy_skip();
    int c, bad1;
    clear_logs();
    force_busy = 4'b0010;
    for (int f = 0; f < 2; f++) begin
      c = rr_pick(exp_dptr, ~force_busy);
      exp_dptr = (c + 1) % N;
      push_frame(c);
    end
    drive();
    wait_writes(2 * FW, 2 * FW + 100);
    step();
    check_frames(2, 8);
    bad1 = 0;
    foreach (wr_log[k]) if (wr_log[k].mask[1]) bad1++;
    checks++; if (bad1 != 0) begin errors++; $display("[TB] FAIL busy_core_written: got %0d writes to core 1 expected 0", bad1); end
    force_busy = '0;
    drive();
  endtask

  task automatic test_flow_control();
    int c;
    clear_logs();
    full_mode = 1'b1;
    stall_pct = 40;
    wr_full_viol = 0;
    rden_bad = 0;
    for (int f = 0; f < 3; f++) begin
      c = rr_pick(exp_dptr, ~force_busy);
      exp_dptr = (c + 1) % N;
      push_frame(c);
    end
    drive();
    wait_writes(3 * FW, 5000);
    step();
    full_mode = 1'b0;
    stall_pct = 0;
    drive();
    check_frames(3, 10);
    checks++; if (wr_full_viol != 0) begin errors++; $display("[TB] FAIL write_while_full: got %0d expected 0", wr_full_viol); end
    checks++; if (rden_bad != 0) begin errors++; $display("[TB] FAIL rden_vs_write: got %0d inconsistent cycles expected 0", rden_bad); end
  endtask

  task automatic test_collector();
    logic [31:0] exp_out[$];
    int t, bad, first;
    clear_logs();
    out_full_viol = 0;
    res_pop_bad = 0;
    first = rr_pick(0, 4'b0101);
    for (int j = 0; j < 3; j++) begin
      res_q[0].push_back($urandom());
      res_q[2].push_back($urandom());
    end
    for (int j = 0; j < 3; j++) exp_out.push_back(res_q[first][j]);
    for (int j = 0; j < 3; j++) exp_out.push_back(res_q[rr_pick(first + 1, 4'b0101)][j]);
    drive();
    t = 0;
    while (out_log.size() < 1 && t < 20) begin step(); t++; end
    ofull_cnt = 5;
    drive();
    t = 0;
    while (out_log.size() < 6 && t < 60) begin step(); t++; end
    repeat (3) step();
    checks++; if (out_log.size() != 6) begin errors++; $display("[TB] FAIL out_count: got %0d expected 6", out_log.size()); end
    else begin
      bad = 0;
      for (int j = 0; j < 6; j++) if (out_log[j] !== exp_out[j]) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL out_order: %0d words wrong, first got %h expected %h", bad, out_log[0], exp_out[0]); end
    end
    checks++; if (out_full_viol != 0) begin errors++; $display("[TB] FAIL write_while_out_full: got %0d expected 0", out_full_viol); end
    checks++; if (res_pop_bad != 0) begin errors++; $display("[TB] FAIL pop_while_empty: got %0d expected 0", res_pop_bad); end
    checks++; if (n_collected !== 32'd2) begin errors++; $display("[TB] FAIL n_collected: got %0d expected 2", n_collected); end
  endtask

  task automatic test_reset_mid_stream();
    int c;
    clear_logs();
    c = rr_pick(exp_dptr, ~force_busy);
    push_frame(c);
    drive();
    wait_writes(100, 300);
    checks++; if (wr_log.size() != 100) begin errors++; $display("[TB] FAIL pre_reset_writes: got %0d expected 100", wr_log.size()); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (in_rden !== 1'b0 || core_fifo_wren !== '0) begin errors++; $display("[TB] FAIL async_reset_path: in_rden %b wren %b expected 0/0", in_rden, core_fifo_wren); end
    checks++; if (n_dispatched !== 32'd0 || n_collected !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_counters: got %0d/%0d expected 0/0", n_dispatched, n_collected); end
    checks++; if (ref_loaded !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ref_loaded: got %b expected 0", ref_loaded); end
    up_q.delete();
    for (int i = 0; i < N; i++) begin
      res_q[i].delete();
      btimer[i] = 0;
    end
    load_done_k = '0;
    force_busy = '0;
    drive();
    repeat (3) step();
    rst = 1'b0;
    clear_logs();
    repeat (10) step();
    checks++; if (wr_log.size() != 0 || rs_log.size() != 0) begin errors++; $display("[TB] FAIL post_reset_activity: writes %0d rs %0d expected 0/0", wr_log.size(), rs_log.size()); end
    checks++; if (ref_loaded !== 1'b0 || n_dispatched !== 32'd0) begin errors++; $display("[TB] FAIL post_reset_state: ref_loaded %b n_dispatched %0d expected 0/0", ref_loaded, n_dispatched); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_ref_len_zero();
    test_ref_load();
    test_reload_ignored();
    test_back_to_back();
    test_busy_skip();
    test_flow_control();
    test_collector();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
